// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

  localparam int unsigned PC_STEP         = 4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Sequential fetch address; mem_bytes is a power of two, so the mask is the modulo.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input int unsigned mem_bytes);
    return (pc + PC_STEP) & (mem_bytes - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; emptiness comes from the pointers, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: drives mem_pc, buffers returned words, hands {instr, pc} to decode.
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                MEM_BYTES  = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_pc,
  input  logic [31:0]       mem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy
);

  localparam int ENTRY_W = 32 + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_redirect_tgt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ENTRY_W-1:0] w_head;

  assign w_pc_inc       = ADDR_W'(next_pc(32'(r_fetch_pc), MEM_BYTES));
  assign w_redirect_tgt = redirect_pc & ADDR_W'(WORD_ALIGN_MASK) & ADDR_W'(MEM_BYTES - 1);
  assign w_pop          = !w_empty && inst_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    case (r_state)
      ST_WAIT:   w_state_nxt = halt ? ST_HALTED : ST_RUN;
      ST_RUN: begin
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (!redirect_valid && (!w_full || w_pop)) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = w_pc_inc;
        end
      end
      ST_HALTED: if (!halt) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_WAIT;
    endcase
    if (redirect_valid) w_fetch_pc_nxt = w_redirect_tgt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_WAIT;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata ({mem_instr, r_fetch_pc}),
    .full  (w_full),
    .empty (w_empty),
    .rdata (w_head)
  );

  assign mem_pc     = r_fetch_pc;
  assign inst_valid = !w_empty;
  assign inst_data  = w_empty ? '0 : w_head[ENTRY_W-1 -: 32];
  assign inst_pc    = w_empty ? '0 : w_head[ADDR_W-1:0];
  // WAIT counts as idle so busy reads 0 while reset holds the block.
  assign busy       = (r_state == ST_RUN) || !w_empty;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a byte-addressed little-endian memory model.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_pc;
  logic [31:0] mem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] words [8] = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
                             32'h00c5c533, 32'h01bd5f33, 32'h40e78733, 32'h00f768b3};
  logic [7:0]  mem_image [32];

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .mem_pc         (mem_pc),
    .mem_instr      (mem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
  );

  always_comb begin
    int a;
    a = int'(mem_pc[4:0] & 5'b11100);
    mem_instr = {mem_image[a+3], mem_image[a+2], mem_image[a+1], mem_image[a]};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
    check({tag, " valid"}, 32'(inst_valid), 32'd1);
    check({tag, " pc"}, inst_pc, pc);
    check({tag, " data"}, inst_data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++)
        mem_image[4*w+b] = words[w][8*b +: 8];

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    check("rst valid", 32'(inst_valid), 32'd0);
    check("rst data", inst_data, 32'h0);
    check("rst pc", inst_pc, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst mem_pc", mem_pc, 32'h0);

    // Streaming with decode always ready, through the 0x1C -> 0x00 wrap.
    reset = 1'b1; inst_ready = 1'b1;
    tick();
    check("lat wait valid", 32'(inst_valid), 32'd0);
    tick();
    check_head("lat first", 32'h00, 32'h00940333);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_head($sformatf("stream%0d", k), (4 * k) % 32, words[k % 8]);
    end

    // Decode stalled from the start: FIFO fills, mem_pc parks.
    reset = 1'b0; inst_ready = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check_head("stall head", 32'h00, 32'h00940333);
    check("stall mem_pc", mem_pc, 32'h08);
    inst_ready = 1'b1;
    tick();
    check_head("unstall1", 32'h04, 32'h413903b3);
    tick();
    check_head("unstall2", 32'h08, 32'h035a02b3);

    // Misaligned redirect with a full FIFO {0x08, 0x0C}.
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h16;
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    check("redir valid", 32'(inst_valid), 32'd0);
    check("redir mem_pc", mem_pc, 32'h14);
    tick();
    check_head("redir first", 32'h14, 32'h01bd5f33);
    inst_ready = 1'b1;
    tick();
    check_head("redir second", 32'h18, 32'h40e78733);

    // Halt with two entries buffered {0x18, 0x1C}.
    inst_ready = 1'b0;
    tick();
    check("halt pre mem_pc", mem_pc, 32'h00);
    halt = 1'b1; inst_ready = 1'b1;
    tick();
    check_head("halt drain1", 32'h1C, 32'h00f768b3);
    check("halt drain busy", 32'(busy), 32'd1);
    tick();
    check("halt empty valid", 32'(inst_valid), 32'd0);
    check("halt empty busy", 32'(busy), 32'd0);
    check("halt mem_pc", mem_pc, 32'h00);
    tick();
    check("halt hold mem_pc", mem_pc, 32'h00);
    check("halt hold valid", 32'(inst_valid), 32'd0);
    halt = 1'b0;
    tick();
    check("resume gap valid", 32'(inst_valid), 32'd0);
    tick();
    check_head("resume first", 32'h00, 32'h00940333);

    // Reset mid-stream with a full FIFO {0x00, 0x04}.
    inst_ready = 1'b0;
    tick();
    check("prerst mem_pc", mem_pc, 32'h08);
    reset = 1'b0;
    tick();
    check("midrst valid", 32'(inst_valid), 32'd0);
    check("midrst mem_pc", mem_pc, 32'h00);
    check("midrst busy", 32'(busy), 32'd0);
    reset = 1'b1; inst_ready = 1'b1;
    tick();
    check("restart wait valid", 32'(inst_valid), 32'd0);
    tick();
    check_head("restart first", 32'h00, 32'h00940333);
    tick();
    check_head("restart second", 32'h04, 32'h413903b3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
